// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-RAM bridge.
// FSM state encoding and the command byte values.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE
    } spi_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

endpackage

// File: rtl/spi_ram_bridge_sync.sv
// 2-FF synchroniser plus registered edge detector for one SPI pin.
// Strobes appear 3 clk cycles after the pin edge.
module spi_sync_edge
    import spi_bridge_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // next-state: shift the pin through the chain, compare last two stages
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
        rise_d = s2_q & ~prev_q;
        fall_d = ~s2_q & prev_q;
    end

    // synchroniser and edge flops
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = s2_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI mode-0 slave giving a host word access to one RAM port.
// Command, address, then auto-incrementing data words.
module spi_ram_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] BYTE_LAST = CW'(7);
    localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sig_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(spi_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign sig_unused = sclk_lvl ^ cs_rise ^ mosi_rise ^ mosi_fall;

    spi_state_t            state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [1:0]            settle_q, settle_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] rx_word;

    assign rx_word = {rx_q[DATA_WIDTH-2:0], mosi_lvl};

    // frame decoder: CS-high abort first, then per-state bit handling
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        cmd_err_d = cmd_err_q;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        // a frame already open at reset must not start until CS is seen high
        armed_d   = armed_q | ((settle_q == 2'd3) & cs_lvl);

        if (mem_en_q && mem_we_q) begin
            addr_d = addr_q + 1'b1;
        end
        if (mem_en_q && !mem_we_q) begin
            tx_d = mem_rdata;
        end

        if (cs_lvl) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        rx_d      = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_d      = rx_word;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BYTE_LAST) begin
                            bit_cnt_d = '0;
                            if (rx_word[7:0] == CMD_WRITE) begin
                                state_d   = ST_ADDR;
                                wr_d      = 1'b1;
                                cmd_err_d = 1'b0;
                            end else if (rx_word[7:0] == CMD_READ) begin
                                state_d   = ST_ADDR;
                                wr_d      = 1'b0;
                                cmd_err_d = 1'b0;
                            end else begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        rx_d      = rx_word;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BYTE_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = rx_word[ADDR_WIDTH-1:0];
                            if (wr_q) begin
                                state_d = ST_WR_DATA;
                            end else begin
                                state_d  = ST_RD_DATA;
                                mem_en_d = 1'b1;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (sclk_rise) begin
                        rx_d      = rx_word;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == WORD_LAST) begin
                            bit_cnt_d = '0;
                            wdata_d   = rx_word;
                            mem_en_d  = 1'b1;
                            mem_we_d  = 1'b1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == WORD_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + 1'b1;
                            mem_en_d  = 1'b1;
                        end
                    end else if (sclk_fall && bit_cnt_q != '0) begin
                        // no shift on the fall before a word's first bit
                        tx_d = tx_q << 1;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // bridge state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            cmd_err_q <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            cmd_err_q <= cmd_err_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
        end
    end

    assign spi_miso  = (state_q == ST_RD_DATA) & tx_q[DATA_WIDTH-1];
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench for spi_ram_bridge: SPI host model, RAM model,
// expected writes/reads queued at stimulus time and checked by a monitor.
module tb_spi_ram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        cmd_err;

    always #5 clk = ~clk;

    spi_ram_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    logic [31:0] ram [256];
    logic [31:0] model [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rd_got[$];
    logic [31:0] wdat[$];
    wr_t         mon_e;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int en_count = 0;
    int half = 4;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // monitor: every RAM write and every received read word is scored
    always @(negedge clk) begin
        if (!rst && mem_en) begin
            en_count++;
            if (mem_we) begin
                we_count++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h",
                             mem_addr, mem_wdata);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(mon_e.a));
                    chk("wr_data", 64'(mem_wdata), 64'(mon_e.d));
                end
            end
        end
        if (rd_got.size() > 0) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read got=%0h", rd_got.pop_front());
            end else begin
                chk("rd_word", 64'(rd_got.pop_front()), 64'(exp_rd.pop_front()));
            end
        end
    end

    task automatic hwait();
        repeat (half) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, output logic got);
        spi_mosi = b;
        hwait();
        got = spi_miso;
        spi_sclk = 1'b1;
        hwait();
        spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n,
                             output logic [31:0] r);
        logic g;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(w[i], g);
            r = {r[30:0], g};
        end
    endtask

    task automatic cs_low();
        @(posedge clk);
        #2;
        spi_cs_n = 1'b0;
    endtask

    task automatic cs_high();
        hwait();
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic frame_write(input logic [7:0] a, input int n);
        logic [31:0] r;
        logic [7:0]  ad;
        cs_low();
        send_bits(32'h02, 8, r);
        send_bits(32'(a), 8, r);
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            exp_wr.push_back('{a: ad, d: wdat[i]});
            model[ad] = wdat[i];
            send_bits(wdat[i], 32, r);
        end
        cs_high();
    endtask

    task automatic frame_read(input logic [7:0] a, input int n);
        logic [31:0] r;
        logic [7:0]  ad;
        cs_low();
        send_bits(32'h03, 8, r);
        send_bits(32'(a), 8, r);
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            exp_rd.push_back(model[ad]);
            send_bits(32'h0, 32, r);
            rd_got.push_back(r);
        end
        cs_high();
    endtask

    initial begin
        logic [31:0] r;
        int          we0;
        int          en0;
        logic [7:0]  ra;
        int          rn;

        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #2;
            pl_we   = 1'b1;
            pl_addr = 8'(i);
            pl_data = $urandom;
            model[i] = pl_data;
        end
        @(posedge clk);
        #2;
        pl_we = 1'b0;

        // reset state
        chk("rst_miso", 64'(spi_miso), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cmd_err", 64'(cmd_err), 64'(0));
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;

        // single write
        wdat = '{32'hDEADBEEF};
        we0 = we_count;
        frame_write(8'h10, 1);
        chk("t1_one_write", 64'(we_count - we0), 64'(1));

        // burst read across the address wrap
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            pl_we   = 1'b1;
            pl_addr = 8'hFE + 8'(i);
            pl_data = 32'h11111111 * (i + 1);
            model[pl_addr] = pl_data;
        end
        @(posedge clk);
        #2;
        pl_we = 1'b0;
        we0 = we_count;
        frame_read(8'hFE, 3);
        chk("t2_no_write", 64'(we_count - we0), 64'(0));

        // partial word is dropped, busy clears quickly
        we0 = we_count;
        cs_low();
        send_bits(32'h02, 8, r);
        send_bits(32'h05, 8, r);
        chk("t3_busy_mid", 64'(busy), 64'(1));
        send_bits($urandom, 20, r);
        @(posedge clk);
        #1;
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_busy_clear", 64'(busy), 64'(0));
        repeat (8) @(posedge clk);
        #2;
        chk("t3_no_write", 64'(we_count - we0), 64'(0));

        // unknown command: sticky error, no RAM access
        en0 = en_count;
        cs_low();
        send_bits(32'h7A, 8, r);
        send_bits(32'h30, 8, r);
        chk("t4_err_set", 64'(cmd_err), 64'(1));
        send_bits($urandom, 32, r);
        cs_high();
        chk("t4_err_sticky", 64'(cmd_err), 64'(1));
        chk("t4_no_access", 64'(en_count - en0), 64'(0));
        frame_read(8'h10, 1);
        chk("t4_err_clear", 64'(cmd_err), 64'(0));

        // reset in the middle of a write burst
        we0 = we_count;
        cs_low();
        send_bits(32'h02, 8, r);
        send_bits(32'h40, 8, r);
        exp_wr.push_back('{a: 8'h40, d: 32'hCAFEF00D});
        model[8'h40] = 32'hCAFEF00D;
        send_bits(32'hCAFEF00D, 32, r);
        send_bits(32'h12345678, 16, r);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("t5_idle_after_rst", 64'(busy), 64'(0));
        send_bits(32'h9ABC, 16, r);
        send_bits(32'h55555555, 32, r);
        chk("t5_still_idle", 64'(busy), 64'(0));
        cs_high();
        chk("t5_one_write", 64'(we_count - we0), 64'(1));
        wdat = '{32'h0BADC0DE};
        frame_write(8'h41, 1);
        frame_read(8'h40, 2);

        // back-to-back frames at clk/8
        half = 4;
        wdat = '{32'hA5A5A5A5};
        frame_write(8'h20, 1);
        frame_read(8'h20, 1);

        // randomized bursts, some at slower SCLK
        for (int k = 0; k < 8; k++) begin
            half = 4 + int'($urandom_range(0, 2));
            ra = 8'($urandom);
            rn = int'($urandom_range(1, 3));
            wdat.delete();
            for (int i = 0; i < rn; i++) wdat.push_back($urandom);
            if (k % 2 == 0) frame_write(ra, rn);
            frame_read(ra - 8'd1, rn + 1);
        end
        half = 4;

        repeat (20) @(posedge clk);
        #2;
        chk("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
